// File: rtl/stream_mux_pkg.sv
// ============================================================================
// stream_mux_pkg : shared types and defaults for the 2:1 stream merger
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_mux_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        SRC_CH0 = 1'b0,
        SRC_CH1 = 1'b1
    } src_t;

endpackage

`default_nettype wire

// File: rtl/stream_mux2x1_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-requester round-robin arbiter owning the last-served pointer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import stream_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output src_t       gnt_idx
);

    src_t r_last;

    always_comb begin
        gnt_idx = SRC_CH0;
        gnt     = 2'b00;
        case (req)
            2'b01: begin
                gnt_idx = SRC_CH0;
                gnt     = 2'b01;
            end
            2'b10: begin
                gnt_idx = SRC_CH1;
                gnt     = 2'b10;
            end
            2'b11: begin
                // Contention: serve whichever channel was not served last
                gnt_idx = (r_last == SRC_CH0) ? SRC_CH1 : SRC_CH0;
                gnt     = (r_last == SRC_CH0) ? 2'b10 : 2'b01;
            end
            default: begin
                gnt_idx = SRC_CH0;
                gnt     = 2'b00;
            end
        endcase
    end

    // Reset to CH1 so channel 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SRC_CH1;
        end else if (advance) begin
            r_last <= gnt_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_mux2x1.sv
// ============================================================================
// stream_mux2x1 : round-robin 2:1 valid/ready stream merger, registered output
// Optional macro STREAM_MUX_SRC_TAG_EN adds the m_src source-channel tag.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux2x1
    import stream_mux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    output logic              s1_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
`ifdef STREAM_MUX_SRC_TAG_EN
    ,
    output logic              m_src
`endif
);

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              w_load;
    logic              w_xfer;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    src_t              w_gnt_idx;
    logic [DATA_W-1:0] w_sel_data;

    assign w_req  = {s1_valid, s0_valid};
    assign w_load = !r_m_valid || m_ready;
    // rst_n gating keeps both readies low for the whole reset window
    assign w_xfer = rst_n && w_load && (|w_req);

    assign s0_ready = rst_n && w_load && w_gnt[0];
    assign s1_ready = rst_n && w_load && w_gnt[1];

    assign w_sel_data = (w_gnt_idx == SRC_CH1) ? s1_data : s0_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_xfer),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_sel_data;
            end else begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

`ifdef STREAM_MUX_SRC_TAG_EN
    src_t r_m_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_src <= SRC_CH0;
        end else if (w_xfer) begin
            r_m_src <= w_gnt_idx;
        end
    end

    assign m_src = r_m_src;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_mux2x1.sv
// ============================================================================
// tb_stream_mux2x1 : directed self-checking bench for stream_mux2x1
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux2x1;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              s0_valid;
    logic [DATA_W-1:0] s0_data;
    logic              s0_ready;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
`ifdef STREAM_MUX_SRC_TAG_EN
    logic              m_src;
`endif

    int errors = 0;
    int checks = 0;

    stream_mux2x1 #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_ready (s1_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready)
`ifdef STREAM_MUX_SRC_TAG_EN
        ,
        .m_src    (m_src)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source-side protocol: a stalled beat must keep its payload
    logic              r_hold0, r_hold1;
    logic [DATA_W-1:0] r_prev0, r_prev1;
    always @(posedge clk) begin
        if (rst_n && r_hold0 && s0_valid)
            assert (s0_data === r_prev0) else $error("FAIL s0_hold: observed=%0h expected=%0h", s0_data, r_prev0);
        if (rst_n && r_hold1 && s1_valid)
            assert (s1_data === r_prev1) else $error("FAIL s1_hold: observed=%0h expected=%0h", s1_data, r_prev1);
        r_hold0 <= s0_valid && !s0_ready;
        r_hold1 <= s1_valid && !s1_ready;
        r_prev0 <= s0_data;
        r_prev1 <= s1_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] c_seq [3];

    initial begin
        c_seq[0] = 8'h11; c_seq[1] = 8'h22; c_seq[2] = 8'h33;
        rst_n = 1'b0; m_ready = 1'b1;
        s0_valid = 1'b1; s0_data = 8'h11;
        s1_valid = 1'b1; s1_data = 8'h99;

        // Reset held with both sources requesting
        step(); step();
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
        check("rst_s1_ready", {31'd0, s1_ready}, 32'd0);

        rst_n = 1'b1; #1;
        check("first_s0_ready", {31'd0, s0_ready}, 32'd1);
        check("first_s1_ready", {31'd0, s1_ready}, 32'd0);
        step();
        check("first_m_valid", {31'd0, m_valid}, 32'd1);
        check("first_m_data", {24'd0, m_data}, 32'h11);
        s0_valid = 1'b0; s1_valid = 1'b0;
        step();
        check("idle_m_valid", {31'd0, m_valid}, 32'd0);
        check("idle_m_data_hold", {24'd0, m_data}, 32'h11);

        // Single channel back-to-back, last=0 now
        for (int i = 0; i < 3; i++) begin
            s0_valid = 1'b1; s0_data = c_seq[i]; #1;
            check("single_s0_ready", {31'd0, s0_ready}, 32'd1);
            step();
            check("single_m_valid", {31'd0, m_valid}, 32'd1);
            check("single_m_data", {24'd0, m_data}, {24'd0, c_seq[i]});
        end
        s0_valid = 1'b0;

        // Contention: last=0, so channel 1 goes first, then alternate
        s0_valid = 1'b1; s0_data = 8'hA0;
        s1_valid = 1'b1; s1_data = 8'hB0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_s1_ready", {31'd0, s1_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_s0_ready", {31'd0, s0_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check("cont_m_data", {24'd0, m_data}, (k % 2 == 0) ? 32'hB0 : 32'hA0);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        step();
        check("cont_drain_m_valid", {31'd0, m_valid}, 32'd0);

        // Backpressure with a pending channel-1 beat
        s0_valid = 1'b1; s0_data = 8'h5A; #1;
        check("bp_s0_ready", {31'd0, s0_ready}, 32'd1);
        step();
        check("bp_load_data", {24'd0, m_data}, 32'h5A);
        s0_valid = 1'b0; m_ready = 1'b0;
        s1_valid = 1'b1; s1_data = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_m_valid", {31'd0, m_valid}, 32'd1);
            check("bp_m_data", {24'd0, m_data}, 32'h5A);
            check("bp_s0_ready", {31'd0, s0_ready}, 32'd0);
            check("bp_s1_ready", {31'd0, s1_ready}, 32'd0);
            step();
        end
        m_ready = 1'b1; #1;
        check("bp_release_s1_ready", {31'd0, s1_ready}, 32'd1);
        step();
        check("bp_release_m_valid", {31'd0, m_valid}, 32'd1);
        check("bp_release_m_data", {24'd0, m_data}, 32'hC3);
        s1_valid = 1'b0;
        step();
        check("bp_drain_m_valid", {31'd0, m_valid}, 32'd0);

        // Asynchronous reset while stalled
        s0_valid = 1'b1; s0_data = 8'hE7;
        step();
        check("ar_load_data", {24'd0, m_data}, 32'hE7);
        s0_valid = 1'b0; m_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0; #1;
        check("ar_m_valid", {31'd0, m_valid}, 32'd0);
        check("ar_m_data", {24'd0, m_data}, 32'd0);
        check("ar_s0_ready", {31'd0, s0_ready}, 32'd0);
        check("ar_s1_ready", {31'd0, s1_ready}, 32'd0);
        m_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("ar_no_deliver", {31'd0, m_valid}, 32'd0);
        s0_valid = 1'b1; s0_data = 8'h12;
        s1_valid = 1'b1; s1_data = 8'h34;
        step();
        check("ar_restart_ch0", {24'd0, m_data}, 32'h12);
        s0_valid = 1'b0; s1_valid = 1'b0;
        step();

`ifdef STREAM_MUX_SRC_TAG_EN
        s1_valid = 1'b1; s1_data = 8'h77;
        step();
        check("tag_data1", {24'd0, m_data}, 32'h77);
        check("tag_src1", {31'd0, m_src}, 32'd1);
        s1_valid = 1'b0; s0_valid = 1'b1; s0_data = 8'h66;
        step();
        check("tag_data0", {24'd0, m_data}, 32'h66);
        check("tag_src0", {31'd0, m_src}, 32'd0);
        s0_valid = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
